// File: rtl/elevator_motion_controller.sv
// Cab motion and door sequencer: steps the cab one floor per travel period toward
// i_target_floor, pulses o_floor_reached on arrival, then holds the door open for a dwell.
module elevator_motion_controller #(
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_floor_requests,
  input  logic [1:0] i_target_floor,
  input  logic       i_door_hold,
  output logic [1:0] o_current_floor,
  output logic       o_floor_reached,
  output logic       o_moving_up,
  output logic       o_moving_down,
  output logic       o_door_open,
  output logic       o_busy
);

  localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMoveUp,
    StMoveDown,
    StArrive,
    StDoorOpen
  } state_e;

  state_e        r_state, w_state_next;
  logic [1:0]    r_floor, w_floor_next;
  logic [TW-1:0] r_travel_cnt, w_travel_next;
  logic [DW-1:0] r_door_cnt, w_door_next;

  logic w_floor_reached, w_moving_up, w_moving_down, w_door_open, w_busy;

  // Direction decision at a floor boundary, made against the floor just reached.
  function automatic state_e boundary_state(input logic [1:0] tgt, input logic [1:0] fl);
    if (tgt == 2'd3)    return StIdle;
    else if (tgt == fl) return StArrive;
    else if (tgt > fl)  return StMoveUp;
    else                return StMoveDown;
  endfunction

  // State, floor, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= StIdle;
      r_floor         <= 2'd0;
      r_travel_cnt    <= '0;
      r_door_cnt      <= '0;
      o_floor_reached <= 1'b0;
      o_moving_up     <= 1'b0;
      o_moving_down   <= 1'b0;
      o_door_open     <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_floor         <= w_floor_next;
      r_travel_cnt    <= w_travel_next;
      r_door_cnt      <= w_door_next;
      o_floor_reached <= w_floor_reached;
      o_moving_up     <= w_moving_up;
      o_moving_down   <= w_moving_down;
      o_door_open     <= w_door_open;
      o_busy          <= w_busy;
    end
  end

  // Next-state, floor and counter logic.
  always_comb begin
    w_state_next  = r_state;
    w_floor_next  = r_floor;
    w_travel_next = r_travel_cnt;
    w_door_next   = r_door_cnt;
    case (r_state)
      StIdle: begin
        if (i_floor_requests != 3'b000 && i_target_floor != 2'd3) begin
          if (i_target_floor > r_floor) begin
            w_state_next  = StMoveUp;
            w_travel_next = TRAVEL_LOAD;
          end else if (i_target_floor < r_floor) begin
            w_state_next  = StMoveDown;
            w_travel_next = TRAVEL_LOAD;
          end else if (i_floor_requests[r_floor]) begin
            w_state_next = StArrive;
          end
        end
      end
      StMoveUp, StMoveDown: begin
        if (r_travel_cnt != '0) begin
          w_travel_next = r_travel_cnt - 1'b1;
        end else if ((r_state == StMoveUp && r_floor == 2'd2) ||
                     (r_state == StMoveDown && r_floor == 2'd0)) begin
          // Already at the end of the shaft: stop rather than wrap.
          w_state_next = StIdle;
        end else begin
          w_floor_next  = (r_state == StMoveUp) ? r_floor + 2'd1 : r_floor - 2'd1;
          w_state_next  = boundary_state(i_target_floor, w_floor_next);
          w_travel_next = TRAVEL_LOAD;
        end
      end
      StArrive: begin
        w_state_next = StDoorOpen;
        w_door_next  = DOOR_LOAD;
      end
      StDoorOpen: begin
        if (i_door_hold) begin
          w_door_next = DOOR_LOAD;
        end else if (r_door_cnt == '0) begin
          w_state_next = StIdle;
        end else begin
          w_door_next = r_door_cnt - 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decode the next state so they are valid in the cycle the state is entered.
  always_comb begin
    w_floor_reached = (w_state_next == StArrive);
    w_moving_up     = (w_state_next == StMoveUp);
    w_moving_down   = (w_state_next == StMoveDown);
    w_door_open     = (w_state_next == StDoorOpen);
    w_busy          = (w_state_next != StIdle);
  end

  assign o_current_floor = r_floor;

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Directed bench for elevator_motion_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=6.
module tb_elevator_motion_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [1:0] tgt = 2'd0;
  logic       hold = 1'b0;
  logic [1:0] cur_floor;
  logic       reached, up, down, door, busy;

  int n_chk  = 0;
  int n_pass = 0;

  elevator_motion_controller #(
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_floor_requests(req),
    .i_target_floor  (tgt),
    .i_door_hold     (hold),
    .o_current_floor (cur_floor),
    .o_floor_reached (reached),
    .o_moving_up     (up),
    .o_moving_down   (down),
    .o_door_open     (door),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       rst;
    logic [2:0] req;
    logic [1:0] tgt;
    logic       hold;
    logic [1:0] f;
    logic       rch, up, dn, door, busy;
    string      name;
  } vec_t;

  vec_t tbl[$];

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic cyc(input logic r, input logic [2:0] q, input logic [1:0] t, input logic h);
    rst  = r;
    req  = q;
    tgt  = t;
    hold = h;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] f, input logic rc, input logic u,
                     input logic d, input logic dr, input logic b);
    logic [6:0] act, exp;
    act = {cur_floor, reached, up, down, door, busy};
    exp = {f, rc, u, d, dr, b};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got floor/rch/up/dn/door/busy=%b required %b",
                  name, $time, act, exp);
  endtask

  initial begin
    //                n rst req     tgt hold  f rch up dn door busy
    tbl.push_back('{2, 1, 3'b000, 0, 0,    0, 0, 0, 0, 0, 0, "reset"});
    tbl.push_back('{3, 0, 3'b000, 0, 0,    0, 0, 0, 0, 0, 0, "idle_noreq"});
    tbl.push_back('{4, 0, 3'b100, 2, 0,    0, 0, 1, 0, 0, 1, "up_f0"});
    tbl.push_back('{4, 0, 3'b100, 2, 0,    1, 0, 1, 0, 0, 1, "up_f1"});
    tbl.push_back('{1, 0, 3'b100, 2, 0,    2, 1, 0, 0, 0, 1, "arrive_f2"});
    tbl.push_back('{6, 0, 3'b000, 2, 0,    2, 0, 0, 0, 1, 1, "door_f2"});
    tbl.push_back('{2, 0, 3'b000, 2, 0,    2, 0, 0, 0, 0, 0, "idle_f2"});
    tbl.push_back('{4, 0, 3'b001, 0, 0,    2, 0, 0, 1, 0, 1, "down_f2"});
    tbl.push_back('{4, 0, 3'b001, 0, 0,    1, 0, 0, 1, 0, 1, "down_f1"});
    tbl.push_back('{1, 0, 3'b001, 0, 0,    0, 1, 0, 0, 0, 1, "arrive_f0"});
    tbl.push_back('{6, 0, 3'b000, 0, 0,    0, 0, 0, 0, 1, 1, "door_f0"});
    tbl.push_back('{1, 0, 3'b000, 0, 0,    0, 0, 0, 0, 0, 0, "idle_f0"});
    tbl.push_back('{2, 0, 3'b010, 3, 0,    0, 0, 0, 0, 0, 0, "tgt3_ignored"});
    tbl.push_back('{2, 0, 3'b010, 0, 0,    0, 0, 0, 0, 0, 0, "same_floor_no_bit"});
    tbl.push_back('{1, 0, 3'b001, 0, 0,    0, 1, 0, 0, 0, 1, "same_floor_arrive"});
    tbl.push_back('{6, 0, 3'b000, 0, 0,    0, 0, 0, 0, 1, 1, "same_floor_door"});
    tbl.push_back('{1, 0, 3'b000, 0, 0,    0, 0, 0, 0, 0, 0, "same_floor_idle"});

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        cyc(tbl[i].rst, tbl[i].req, tbl[i].tgt, tbl[i].hold);
        chk(tbl[i].name, tbl[i].f, tbl[i].rch, tbl[i].up, tbl[i].dn, tbl[i].door, tbl[i].busy);
      end
    end

    // Door hold: raised during the 3rd door cycle for 5 cycles, then 6 more open cycles.
    cyc(0, 3'b001, 0, 0); chk("hold_arrive", 0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin cyc(0, 3'b000, 0, 0); chk("hold_pre", 0, 0, 0, 0, 1, 1); end
    for (int k = 0; k < 5; k++) begin cyc(0, 3'b000, 0, 1); chk("hold_high", 0, 0, 0, 0, 1, 1); end
    for (int k = 0; k < 5; k++) begin cyc(0, 3'b000, 0, 0); chk("hold_post", 0, 0, 0, 0, 1, 1); end
    cyc(0, 3'b000, 0, 0); chk("hold_close", 0, 0, 0, 0, 0, 0);

    // Retarget 2 -> 1 before the first boundary: stop at floor 1.
    for (int k = 0; k < 2; k++) begin cyc(0, 3'b100, 2, 0); chk("rt_up_f0", 0, 0, 1, 0, 0, 1); end
    for (int k = 0; k < 2; k++) begin cyc(0, 3'b010, 1, 0); chk("rt_up_f0b", 0, 0, 1, 0, 0, 1); end
    cyc(0, 3'b010, 1, 0); chk("rt_arrive_f1", 1, 1, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin cyc(0, 3'b000, 1, 0); chk("rt_door_f1", 1, 0, 0, 0, 1, 1); end
    cyc(0, 3'b000, 1, 0); chk("rt_idle_f1", 1, 0, 0, 0, 0, 0);

    // Retarget to 0 while moving up from 1: reverses at the floor 2 boundary.
    cyc(0, 3'b100, 2, 0); chk("rev_up_f1", 1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin cyc(0, 3'b001, 0, 0); chk("rev_up_f1b", 1, 0, 1, 0, 0, 1); end
    for (int k = 0; k < 4; k++) begin cyc(0, 3'b001, 0, 0); chk("rev_down_f2", 2, 0, 0, 1, 0, 1); end
    for (int k = 0; k < 4; k++) begin cyc(0, 3'b001, 0, 0); chk("rev_down_f1", 1, 0, 0, 1, 0, 1); end
    cyc(0, 3'b001, 0, 0); chk("rev_arrive_f0", 0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin cyc(0, 3'b000, 0, 0); chk("rev_door_f0", 0, 0, 0, 0, 1, 1); end
    cyc(0, 3'b000, 0, 0); chk("rev_idle_f0", 0, 0, 0, 0, 0, 0);

    // Reset mid-travel after 6 cycles of a 0 -> 2 trip.
    for (int k = 0; k < 4; k++) begin cyc(0, 3'b100, 2, 0); chk("rst_up_f0", 0, 0, 1, 0, 0, 1); end
    for (int k = 0; k < 2; k++) begin cyc(0, 3'b100, 2, 0); chk("rst_up_f1", 1, 0, 1, 0, 0, 1); end
    cyc(1, 3'b100, 2, 0); chk("rst_mid_travel", 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin cyc(0, 3'b000, 0, 0); chk("rst_after_idle", 0, 0, 0, 0, 0, 0); end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/elevator_motion_controller.md
Name: elevator_motion_controller

Overview:
Cab motion and door sequencer directly downstream of the request handler. Consumes floor_requests and target_floor. Moves the cab one floor at a time using a per-floor travel timer, then opens the door for a timed dwell. Produces current_floor and the one-cycle floor_reached pulse that the request handler uses to clear requests and update passenger state.

Parameters:
TRAVEL_CYCLES, 16, clock cycles to travel one floor (>=2)
DOOR_CYCLES, 32, clock cycles the door stays open after arrival (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
floor_requests  input  3  pending request per floor (bit n = floor n)
target_floor  input  2  floor to serve; value 3 is invalid
door_hold  input  1  obstruction / door-open button; holds door open
current_floor  output  2  floor the cab is at or last passed
floor_reached  output  1  one-cycle pulse on arrival at the served floor
moving_up  output  1  cab travelling upward
moving_down  output  1  cab travelling downward
door_open  output  1  door open command
busy  output  1  state != IDLE

Behaviour:
- Reset is synchronous and active-high; it is checked first on every clk edge and overrides everything, including mid-travel and door-open states.
  - Reset values: state IDLE, current_floor 0, floor_reached 0, moving_up 0, moving_down 0, door_open 0, busy 0, both counters 0.
  - Homing of the physical cab is out of scope.
- All outputs are registered. moving_up/moving_down/door_open/busy decode the next state, so each is valid in the same cycle the state is entered.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, DOOR_OPEN.
- IDLE:
  - floor_requests==0 or target_floor==3 -> stay.
  - target_floor>current_floor -> MOVE_UP, load travel counter with TRAVEL_CYCLES-1.
  - target_floor<current_floor -> MOVE_DOWN, same counter load.
  - target_floor==current_floor and floor_requests[current_floor]==1 -> ARRIVE.
- MOVE_UP / MOVE_DOWN:
  - Travel counter decrements each cycle.
  - On the cycle it is 0, current_floor increments (up) or decrements (down). This is the floor boundary.
  - At the boundary, re-evaluate target_floor against the new floor:
    - equal -> ARRIVE.
    - further in the same direction -> reload counter, stay in state.
    - opposite direction -> reload counter, switch to the other MOVE state.
    - target_floor==3 -> IDLE, no pulse.
  - target_floor changes between boundaries are only acted on at the next boundary.
  - Saturation: never increment past 2 or decrement below 0. If at floor 2 in MOVE_UP or floor 0 in MOVE_DOWN, go to IDLE.
- ARRIVE:
  - Exactly one cycle; floor_reached=1 registered for that cycle only.
  - Next state DOOR_OPEN, door counter loaded with DOOR_CYCLES-1.
- DOOR_OPEN:
  - door_open=1.
  - Counter decrements each cycle.
  - door_hold=1 reloads the counter to DOOR_CYCLES-1 each cycle it is high.
  - When the counter is 0 and door_hold=0 -> IDLE.
- The ARRIVE+DOOR_OPEN dwell covers the request handler's one-cycle registered update of floor_requests/target_floor. A served request is never re-served unless the handler re-asserts it.
- floor_reached fires only in ARRIVE; never on passing through an intermediate floor.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit.
- moving_up and moving_down are never both 1.
- door_open is never 1 while moving.

Test Plan:
1. Reset check: assert rst for 2 cycles in any state -> next edge all outputs 0, current_floor=0, busy=0; idle with floor_requests=0 -> outputs stay 0.
2. Travel 0->2 (TRAVEL_CYCLES=4, DOOR_CYCLES=6): floor_requests=3'b100, target_floor=2 -> moving_up=1 for 8 cycles; current_floor=1 after 4 cycles and 2 after 8 cycles; one floor_reached pulse at floor 2 only; door_open=1 for 6 cycles; then busy=0.
3. Same-floor call at floor 0: floor_requests=3'b001, target_floor=0 -> no motion, floor_reached on 2nd edge, door_open 6 cycles.
4. Door hold: in DOOR_OPEN, raise door_hold on the 3rd door cycle for 5 cycles -> door_open stays 1 until 6 cycles after door_hold falls.
5. Retarget mid-travel: moving 0->2, change target_floor to 1 before first boundary -> arrive at floor 1, single floor_reached, current_floor=1; target 0 while moving up from 1 -> reverses at floor 2 boundary, moving_down=1.
6. Reset mid-travel: rst at cycle 6 of the 0->2 trip -> next edge current_floor=0, IDLE, moving_up=0, no floor_reached.
